// File: rtl/out_mem_pkg.sv
// Shared types and default sizing for the ping-pong output memory.
package out_mem_pkg;

    localparam int OUT_MEM_ADD_SIZE  = 11;
    localparam int OUT_MEM_DATA_SIZE = 32;
    localparam int OUT_MEM_FRAME_LEN = 2048;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DRAIN  = 2'b10
    } rd_state_t;

    typedef logic bank_idx_t;

endpackage

// File: rtl/out_mem_bank.sv
// Simple dual-port RAM bank: one write port, one read port with registered output.
module out_mem_bank
    import out_mem_pkg::*;
#(
    parameter int ADD_SIZE  = OUT_MEM_ADD_SIZE,
    parameter int DATA_SIZE = OUT_MEM_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADD_SIZE-1:0]  waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADD_SIZE-1:0]  raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADD_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/output_pingpong_buffer.sv
// Ping-pong output memory: frames written by address into one bank, the other streamed out.
// Optional OUT_MEM_LAST_EN adds an out_last frame delimiter on the final word.
module output_pingpong_buffer
    import out_mem_pkg::*;
#(
    parameter int ADD_SIZE  = OUT_MEM_ADD_SIZE,
    parameter int DATA_SIZE = OUT_MEM_DATA_SIZE,
    parameter int FRAME_LEN = OUT_MEM_FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADD_SIZE-1:0]  write_address,
    input  logic [DATA_SIZE-1:0] dataIn,
    input  logic                 frame_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] dataOut,
    output logic [1:0]           bank_full,
    output logic                 addr_err
`ifdef OUT_MEM_LAST_EN
    ,
    output logic                 out_last
`endif
);

    localparam logic [ADD_SIZE:0]   FRAME_END = (ADD_SIZE + 1)'(FRAME_LEN);
    localparam logic [ADD_SIZE-1:0] LAST_ADDR = ADD_SIZE'(FRAME_LEN - 1);

    bank_idx_t             wr_bank;
    bank_idx_t             rd_bank;
    rd_state_t             state;
    logic [ADD_SIZE-1:0]   rd_cnt;
    logic [ADD_SIZE-1:0]   rd_addr;
    logic                  issue;
    logic                  rd_pend;
    logic                  wr_accept;
    logic                  in_range;
    logic                  frame_acc;
    logic                  pop;
    logic                  push;
    logic                  fifo_pop;
    logic                  room;
    logic                  last_out;
    logic                  release_bank;
    logic [2:0]            outstanding;
    logic [2:0]            occupancy;
    logic [DATA_SIZE-1:0]  q0;
    logic [DATA_SIZE-1:0]  q1;
    logic [DATA_SIZE-1:0]  ram_q;
    logic [DATA_SIZE-1:0]  fifo_mem [2];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            fifo_cnt;

    assign in_ready  = !bank_full[wr_bank];
    assign wr_accept = in_valid && in_ready;
    assign in_range  = {1'b0, write_address} < FRAME_END;
    assign frame_acc = frame_done && in_ready;

    out_mem_bank #(
        .ADD_SIZE  (ADD_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_accept && in_range && (wr_bank == 1'b0)),
        .waddr (write_address),
        .wdata (dataIn),
        .re    (issue && (rd_bank == 1'b0)),
        .raddr (rd_addr),
        .rdata (q0)
    );

    out_mem_bank #(
        .ADD_SIZE  (ADD_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_accept && in_range && (wr_bank == 1'b1)),
        .waddr (write_address),
        .wdata (dataIn),
        .re    (issue && (rd_bank == 1'b1)),
        .raddr (rd_addr),
        .rdata (q1)
    );

    // rd_bank only toggles once nothing is in flight, so it safely selects the returning word.
    assign ram_q = rd_bank ? q1 : q0;

    // The word in the RAM output register bypasses the skid FIFO when it is empty.
    assign out_valid = (fifo_cnt != 2'd0) || rd_pend;
    assign pop       = out_valid && out_ready;
    assign push      = rd_pend && !((fifo_cnt == 2'd0) && out_ready);
    assign fifo_pop  = (fifo_cnt != 2'd0) && out_ready;

    always_comb begin
        dataOut = '0;
        if (fifo_cnt != 2'd0) begin
            dataOut = fifo_mem[fifo_rp];
        end else if (rd_pend) begin
            dataOut = ram_q;
        end
    end

    assign outstanding  = {1'b0, fifo_cnt} + {2'b00, rd_pend};
    assign occupancy    = outstanding - {2'b00, pop};
    assign room         = occupancy <= 3'd1;
    assign last_out     = (state == DRAIN) && (outstanding == 3'd1);
    assign release_bank = last_out && pop;

`ifdef OUT_MEM_LAST_EN
    assign out_last = last_out;
`endif

    // Address 0 is issued straight from IDLE so the first word appears two cycles after frame_done.
    always_comb begin
        issue   = 1'b0;
        rd_addr = rd_cnt;
        case (state)
            IDLE: begin
                issue   = bank_full[rd_bank] && room;
                rd_addr = '0;
            end
            STREAM:  issue = room;
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            addr_err  <= 1'b0;
            state     <= IDLE;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= '0;
        end else begin
            if (wr_accept && !in_range) begin
                addr_err <= 1'b1;
            end
            if (frame_acc) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (release_bank) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end

            rd_pend <= issue;

            case (state)
                IDLE: begin
                    if (issue) begin
                        rd_cnt <= ADD_SIZE'(1);
                        state  <= (LAST_ADDR == '0) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        if (rd_cnt == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            rd_cnt <= rd_cnt + ADD_SIZE'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (release_bank) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                fifo_wp <= ~fifo_wp;
            end
            if (fifo_pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wp] <= ram_q;
        end
    end

endmodule

// File: tb/tb_output_pingpong_buffer.sv
// Directed bench for output_pingpong_buffer with FRAME_LEN=4 and 8-word banks.
module tb_output_pingpong_buffer;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int FL = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] write_address;
    logic [DW-1:0] dataIn;
    logic          frame_done;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dataOut;
    logic [1:0]    bank_full;
    logic          addr_err;
`ifdef OUT_MEM_LAST_EN
    logic          out_last;
`endif

    int total = 0;
    int bad   = 0;

    output_pingpong_buffer #(
        .ADD_SIZE  (AW),
        .DATA_SIZE (DW),
        .FRAME_LEN (FL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_address (write_address),
        .dataIn        (dataIn),
        .frame_done    (frame_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dataOut       (dataOut),
        .bank_full     (bank_full),
        .addr_err      (addr_err)
`ifdef OUT_MEM_LAST_EN
        ,
        .out_last      (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid      = 1'b1;
        write_address = a;
        dataIn        = d;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic write_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) begin
            write_word(AW'(i), base + DW'(i));
        end
    endtask

    task automatic send_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready toggles every cycle.
    task automatic collect(input logic [DW-1:0] base, input int n, input int mode);
        int          k = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [DW-1:0] held = '0;
        out_ready = (mode == 1) ? 1'b1 : 1'b1;
        while (k < n && cyc < 40) begin
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", dataOut, held);
            end
            if (mode == 1) begin
                out_ready = ~out_ready;
            end else begin
                out_ready = 1'b1;
            end
`ifdef OUT_MEM_LAST_EN
            if (out_valid) begin
                check("out_last", out_last, (k == FL - 1) ? 1 : 0);
            end
`endif
            stalled = out_valid && !out_ready;
            held    = dataOut;
            if (out_valid && out_ready) begin
                check("data", dataOut, base + DW'(k));
                k++;
            end
            tick();
            cyc++;
        end
        if (k < n) begin
            check("timeout_words", k, n);
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        write_address = '0;
        dataIn        = '0;
        frame_done    = 1'b0;
        out_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_bank_full", bank_full, 0);
        check("rst_addr_err", addr_err, 0);

        // Single frame, latency and full-rate readout.
        write_frame(32'h10);
        send_done();
        check("lat_bank_full", bank_full, 2'b01);
        check("lat_valid_t1", out_valid, 0);
        out_ready = 1'b1;
        tick();
        check("lat_valid_t2", out_valid, 1);
        collect(32'h10, FL, 0);
        check("f1_bank_full", bank_full, 0);
        check("f1_out_valid", out_valid, 0);
        check("f1_in_ready", in_ready, 1);

        // Both banks full under back-pressure.
        out_ready = 1'b0;
        write_frame(32'hA0);
        send_done();
        write_frame(32'hB0);
        send_done();
        tick();
        check("both_bank_full", bank_full, 2'b11);
        check("both_in_ready", in_ready, 0);
        check("both_head", dataOut, 32'hA0);
        collect(32'hA0, FL, 0);
        check("a_done_in_ready", in_ready, 1);
        check("a_done_bank_full", bank_full, 2'b01);
        collect(32'hB0, FL, 1);
        check("b_done_bank_full", bank_full, 0);
        check("b_done_out_valid", out_valid, 0);

        // Out-of-range writes flag addr_err and do not disturb the frame.
        out_ready = 1'b0;
        write_frame(32'h20);
        check("err_boundary_ok", addr_err, 0);
        write_word(3'd4, 32'hDEAD_0004);
        check("err_addr4", addr_err, 1);
        write_word(3'd5, 32'hDEAD_BEEF);
        check("err_addr5", addr_err, 1);
        send_done();
        collect(32'h20, FL, 0);
        check("err_sticky", addr_err, 1);

        // Reset in the middle of a stream.
        out_ready = 1'b0;
        write_frame(32'h30);
        send_done();
        collect(32'h30, 2, 0);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_bank_full", bank_full, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_addr_err", addr_err, 0);
        check("mid_rst_dataOut", dataOut, 0);
        write_frame(32'h40);
        send_done();
        collect(32'h40, FL, 0);
        check("post_rst_bank_full", bank_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
